// File: rtl/hazard_ctrl_pkg.sv
// Shared LC-3b pipeline types used by the hazard controller and its interface.
package lc3b_types;

    localparam int HAZ_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FREEZE    = 2'd1,
        INTERLOCK = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: forwarding/branch/memory status in, pipeline controls and statistics out.
interface hazard_ctrl_if #(
    parameter int CNT_W = lc3b_types::HAZ_CNT_W
);
    import lc3b_types::*;

    logic             sr1_conflict;
    logic             sr2_conflict;
    logic             jmp_conflict;
    logic             is_jmp_id;
    logic             br_taken_mem;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;

    logic             ld_pc;
    logic             ld_if_id;
    logic             ld_id_ex;
    logic             ld_ex_mem;
    logic             ld_mem_wb;
    logic             pc_sel_redirect;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             hazard_err;
    hazard_state_t    state;

    // Pipeline side: reports hazards and consumes the controls.
    modport master (
        output sr1_conflict, sr2_conflict, jmp_conflict, is_jmp_id, br_taken_mem,
               imem_read, imem_resp, dmem_req, dmem_resp,
        input  ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, pc_sel_redirect,
               bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem,
               stall_cnt, bubble_cnt, flush_cnt, hazard_err, state
    );

    modport slave (
        input  sr1_conflict, sr2_conflict, jmp_conflict, is_jmp_id, br_taken_mem,
               imem_read, imem_resp, dmem_req, dmem_resp,
        output ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, pc_sel_redirect,
               bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem,
               stall_cnt, bubble_cnt, flush_cnt, hazard_err, state
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; reset and clr both return it to zero.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage LC-3b hazard controller: combinational stall/flush/bubble priority,
// saturating event statistics and a sticky no-advance watchdog.
module hazard_ctrl
    import lc3b_types::*;
#(
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = HAZ_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam int                  NOADV_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [NOADV_W-1:0]  NOADV_MAX = NOADV_W'(STALL_LIMIT);
    localparam logic [NOADV_W-1:0]  NOADV_PRE = NOADV_W'(STALL_LIMIT - 1);

    logic mem_wait;
    logic data_haz;

    logic ld_pc_next, ld_if_id_next, ld_id_ex_next, ld_ex_mem_next, ld_mem_wb_next;
    logic redirect_next, bubble_next, flush_if_id_next, flush_id_ex_next, flush_ex_mem_next;

    hazard_state_t state_reg;
    logic          hazard_err_reg;
    logic [2:0]    stat_inc;
    logic [CNT_W-1:0] stat_val [3];
    logic [NOADV_W-1:0] noadv;

    assign mem_wait = (hz.imem_read & ~hz.imem_resp) | (hz.dmem_req & ~hz.dmem_resp);
    assign data_haz = hz.sr1_conflict | hz.sr2_conflict | (hz.is_jmp_id & hz.jmp_conflict);

    always_comb begin
        ld_pc_next        = 1'b1;
        ld_if_id_next     = 1'b1;
        ld_id_ex_next     = 1'b1;
        ld_ex_mem_next    = 1'b1;
        ld_mem_wb_next    = 1'b1;
        redirect_next     = 1'b0;
        bubble_next       = 1'b0;
        flush_if_id_next  = 1'b0;
        flush_id_ex_next  = 1'b0;
        flush_ex_mem_next = 1'b0;
        if (mem_wait) begin
            ld_pc_next     = 1'b0;
            ld_if_id_next  = 1'b0;
            ld_id_ex_next  = 1'b0;
            ld_ex_mem_next = 1'b0;
            ld_mem_wb_next = 1'b0;
        end else if (hz.br_taken_mem) begin
            // The hazarding decode instruction is squashed, so its conflict is moot.
            redirect_next     = 1'b1;
            flush_if_id_next  = 1'b1;
            flush_id_ex_next  = 1'b1;
            flush_ex_mem_next = 1'b1;
        end else if (data_haz) begin
            ld_pc_next    = 1'b0;
            ld_if_id_next = 1'b0;
            bubble_next   = 1'b1;
        end
    end

    assign hz.ld_pc           = ld_pc_next;
    assign hz.ld_if_id        = ld_if_id_next;
    assign hz.ld_id_ex        = ld_id_ex_next;
    assign hz.ld_ex_mem       = ld_ex_mem_next;
    assign hz.ld_mem_wb       = ld_mem_wb_next;
    assign hz.pc_sel_redirect = redirect_next;
    assign hz.bubble_id_ex    = bubble_next;
    assign hz.flush_if_id     = flush_if_id_next;
    assign hz.flush_id_ex     = flush_id_ex_next;
    assign hz.flush_ex_mem    = flush_ex_mem_next;

    // Statistics: 0 = stall, 1 = bubble, 2 = flush.
    assign stat_inc = {redirect_next, bubble_next, mem_wait};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            sat_counter #(.WIDTH(CNT_W)) u_stat (
                .clk   (clk),
                .srst  (reset),
                .inc   (stat_inc[gi]),
                .clr   (1'b0),
                .count (stat_val[gi])
            );
        end
    endgenerate

    assign hz.stall_cnt  = stat_val[0];
    assign hz.bubble_cnt = stat_val[1];
    assign hz.flush_cnt  = stat_val[2];

    sat_counter #(.WIDTH(NOADV_W), .MAX(NOADV_MAX)) u_noadv (
        .clk   (clk),
        .srst  (reset),
        .inc   (~ld_pc_next),
        .clr   (ld_pc_next),
        .count (noadv)
    );

    // hazard_err sets on the same edge that noadv reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            hazard_err_reg <= 1'b0;
        end else begin
            if (mem_wait) begin
                state_reg <= FREEZE;
            end else if (data_haz && !hz.br_taken_mem) begin
                state_reg <= INTERLOCK;
            end else begin
                state_reg <= RUN;
            end
            if (!ld_pc_next && (noadv >= NOADV_PRE)) begin
                hazard_err_reg <= 1'b1;
            end
        end
    end

    assign hz.state      = state_reg;
    assign hz.hazard_err = hazard_err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances (default and STALL_LIMIT=4/CNT_W=3)
// driven identically and compared every cycle against a behavioural model.
module tb_hazard_ctrl;
    import lc3b_types::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   step_no;

    hazard_ctrl_if #(.CNT_W(16)) hif_a ();
    hazard_ctrl_if #(.CNT_W(3))  hif_b ();

    hazard_ctrl #(.STALL_LIMIT(64), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (hif_a)
    );

    hazard_ctrl #(.STALL_LIMIT(4), .CNT_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (hif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int            m_stall [2];
    int            m_bub   [2];
    int            m_fl    [2];
    int            m_noadv [2];
    bit            m_err   [2];
    hazard_state_t m_state [2];
    int            m_lim   [2];
    int            m_max   [2];

    logic i_sr1, i_sr2, i_jc, i_isj, i_br, i_ir, i_irs, i_dr, i_drs;

    // Expected controls {ld_pc,ld_if_id,ld_id_ex,ld_ex_mem,ld_mem_wb,redirect,bubble,fl_if,fl_id,fl_ex}.
    function automatic logic [9:0] exp_ctrl();
        bit waiting = (i_ir && !i_irs) || (i_dr && !i_drs);
        bit hazard  = i_sr1 || i_sr2 || (i_isj && i_jc);
        if (waiting)   return 10'b00000_00000;
        if (i_br)      return 10'b11111_10111;
        if (hazard)    return 10'b00111_01000;
        return 10'b11111_00000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [9:0] e;
        logic [9:0] oa;
        logic [9:0] ob;
        e  = exp_ctrl();
        oa = {hif_a.ld_pc, hif_a.ld_if_id, hif_a.ld_id_ex, hif_a.ld_ex_mem, hif_a.ld_mem_wb,
              hif_a.pc_sel_redirect, hif_a.bubble_id_ex, hif_a.flush_if_id, hif_a.flush_id_ex,
              hif_a.flush_ex_mem};
        ob = {hif_b.ld_pc, hif_b.ld_if_id, hif_b.ld_id_ex, hif_b.ld_ex_mem, hif_b.ld_mem_wb,
              hif_b.pc_sel_redirect, hif_b.bubble_id_ex, hif_b.flush_if_id, hif_b.flush_id_ex,
              hif_b.flush_ex_mem};
        check("ctrl_a", 32'(oa), 32'(e));
        check("ctrl_b", 32'(ob), 32'(e));
        check("stall_a", 32'(hif_a.stall_cnt), m_stall[0]);
        check("bubble_a", 32'(hif_a.bubble_cnt), m_bub[0]);
        check("flush_a", 32'(hif_a.flush_cnt), m_fl[0]);
        check("err_a", 32'(hif_a.hazard_err), 32'(m_err[0]));
        check("state_a", 32'(hif_a.state), 32'(m_state[0]));
        check("stall_b", 32'(hif_b.stall_cnt), m_stall[1]);
        check("bubble_b", 32'(hif_b.bubble_cnt), m_bub[1]);
        check("flush_b", 32'(hif_b.flush_cnt), m_fl[1]);
        check("err_b", 32'(hif_b.hazard_err), 32'(m_err[1]));
        check("state_b", 32'(hif_b.state), 32'(m_state[1]));
    endtask

    task automatic model_edge();
        bit waiting = (i_ir && !i_irs) || (i_dr && !i_drs);
        bit hazard  = i_sr1 || i_sr2 || (i_isj && i_jc);
        bit bubble  = !waiting && !i_br && hazard;
        bit redir   = !waiting && i_br;
        bit advance = !waiting && !bubble;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0; m_noadv[k] = 0;
                m_err[k] = 1'b0; m_state[k] = RUN;
            end else begin
                if (waiting) m_stall[k] = (m_stall[k] < m_max[k]) ? m_stall[k] + 1 : m_max[k];
                if (bubble)  m_bub[k]   = (m_bub[k]   < m_max[k]) ? m_bub[k] + 1   : m_max[k];
                if (redir)   m_fl[k]    = (m_fl[k]    < m_max[k]) ? m_fl[k] + 1    : m_max[k];
                if (advance) m_noadv[k] = 0;
                else if (m_noadv[k] < m_lim[k]) m_noadv[k] = m_noadv[k] + 1;
                if (m_noadv[k] == m_lim[k]) m_err[k] = 1'b1;
                m_state[k] = waiting ? FREEZE : (bubble ? INTERLOCK : RUN);
            end
        end
    endtask

    task automatic apply(input logic rst, input logic sr1, input logic sr2, input logic jc,
                         input logic isj, input logic br, input logic ir, input logic irs,
                         input logic dr, input logic drs);
        @(negedge clk);
        reset = rst;
        i_sr1 = sr1; i_sr2 = sr2; i_jc = jc; i_isj = isj; i_br = br;
        i_ir = ir; i_irs = irs; i_dr = dr; i_drs = drs;
        hif_a.sr1_conflict = sr1; hif_b.sr1_conflict = sr1;
        hif_a.sr2_conflict = sr2; hif_b.sr2_conflict = sr2;
        hif_a.jmp_conflict = jc;  hif_b.jmp_conflict = jc;
        hif_a.is_jmp_id    = isj; hif_b.is_jmp_id    = isj;
        hif_a.br_taken_mem = br;  hif_b.br_taken_mem = br;
        hif_a.imem_read    = ir;  hif_b.imem_read    = ir;
        hif_a.imem_resp    = irs; hif_b.imem_resp    = irs;
        hif_a.dmem_req     = dr;  hif_b.dmem_req     = dr;
        hif_a.dmem_resp    = drs; hif_b.dmem_resp    = drs;
        #1;
        check_all();
        $display("step %0d rst=%b in=%b%b%b%b%b%b%b%b%b ld_pc=%b bub=%b redir=%b stall=%0d bubc=%0d flc=%0d err=%b/%b",
                 step_no, rst, sr1, sr2, jc, isj, br, ir, irs, dr, drs, hif_a.ld_pc,
                 hif_a.bubble_id_ex, hif_a.pc_sel_redirect, hif_a.stall_cnt, hif_a.bubble_cnt,
                 hif_a.flush_cnt, hif_a.hazard_err, hif_b.hazard_err);
        step_no++;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        m_lim[0] = 64; m_lim[1] = 4;
        m_max[0] = 65535; m_max[1] = 7;
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0; m_noadv[k] = 0;
            m_err[k] = 1'b0; m_state[k] = RUN;
        end

        // Reset held two cycles with a live SR1 conflict; counting must not start.
        apply(1, 1,0,0,0,0, 0,0,0,0);
        apply(1, 1,0,0,0,0, 0,0,0,0);
        apply(0, 1,0,0,0,0, 0,0,0,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);

        // Load-use interlock for two cycles, then a JMP whose conflict only matters with is_jmp_id.
        apply(0, 0,1,0,0,0, 0,0,0,0);
        apply(0, 0,1,0,0,0, 0,0,0,0);
        apply(0, 0,0,1,0,0, 0,0,0,0);
        apply(0, 0,0,1,1,0, 0,0,0,0);

        // Branch beats hazard.
        apply(0, 1,0,0,0,1, 0,0,0,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);

        // Data-memory freeze holding a branch; response cycle advances and redirects.
        apply(0, 0,0,0,0,1, 0,0,1,0);
        apply(0, 0,0,0,0,1, 0,0,1,0);
        apply(0, 0,0,0,0,1, 0,0,1,0);
        apply(0, 0,0,0,0,1, 0,0,1,1);
        apply(0, 0,0,0,0,0, 1,0,1,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);

        // Watchdog: fetch stuck; dut_b trips after its 4th wait edge and stays set.
        for (int i = 0; i < 6; i++) apply(0, 0,0,0,0,0, 1,0,0,0);
        check("wdog_b_set", 32'(hif_b.hazard_err), 32'd1);
        apply(0, 0,0,0,0,0, 1,1,0,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);
        check("wdog_b_sticky", 32'(hif_b.hazard_err), 32'd1);
        apply(1, 0,0,0,0,0, 0,0,0,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);

        // Saturation: ten bubble cycles pin dut_b's 3-bit counter at 7.
        for (int i = 0; i < 10; i++) apply(0, 1,0,0,0,0, 0,0,0,0);
        apply(0, 0,0,0,0,0, 0,0,0,0);
        check("bubble_b_sat", 32'(hif_b.bubble_cnt), 32'd7);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
